// File: rtl/blake_seq_pkg.sv
// blake_seq_pkg: shared state encoding, round counts and mode encoding for the BLAKE sequencer
package blake_seq_pkg;
  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} state_t;
  localparam int ROUNDS_512 = 16;
  localparam int ROUNDS_256 = 14;
  localparam logic MODE_512 = 1'b0;
  localparam logic MODE_256 = 1'b1;
endpackage

// File: rtl/blake_step_counter.sv
// blake_step_counter: round/step counter pair with wrap and last-step detection
module blake_step_counter #(
  parameter int STEPS_PER_ROUND = 4,
  parameter int RND_W = 4,
  localparam int SW = STEPS_PER_ROUND > 1 ? $clog2(STEPS_PER_ROUND) : 1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             clr,
  input  logic             en,
  input  logic [RND_W-1:0] rnd_limit,
  output logic [RND_W-1:0] round_idx,
  output logic [SW-1:0]    step_idx,
  output logic             last_step
);
  logic step_wrap;
  assign step_wrap = step_idx == SW'(STEPS_PER_ROUND - 1);
  assign last_step = step_wrap && round_idx == rnd_limit;
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      round_idx <= '0;
      step_idx  <= '0;
    end else if (clr || (en && last_step)) begin
      round_idx <= '0;
      step_idx  <= '0;
    end else if (en) begin
      step_idx  <= step_wrap ? '0 : step_idx + 1'b1;
      round_idx <= round_idx + RND_W'(step_wrap);
    end
endmodule

// File: rtl/blake_round_seq.sv
// blake_round_seq: BLAKE-512/256 compression round sequencer FSM; abort port enabled by BLAKE_ABORT_EN
module blake_round_seq
  import blake_seq_pkg::*;
#(
  parameter int STEPS_PER_ROUND = 4,
  parameter int RND_W = 4,
  localparam int SW = STEPS_PER_ROUND > 1 ? $clog2(STEPS_PER_ROUND) : 1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic             last_block,
  output logic             init_round,
  output logic             round_ing,
  output logic [RND_W-1:0] round_idx,
  output logic [SW-1:0]    step_idx,
  output logic             final_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
`ifdef BLAKE_ABORT_EN
  ,
  input  logic             abort
`endif
);
  state_t state, nxt;
  logic mode_q, last_q, last_step, ab;
  logic [RND_W-1:0] rnd_limit;
`ifdef BLAKE_ABORT_EN
  assign ab = abort && state != IDLE;
`else
  assign ab = 1'b0;
`endif
  assign rnd_limit = mode_q == MODE_256 ? RND_W'(ROUNDS_256 - 1) : RND_W'(ROUNDS_512 - 1);
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      state  <= IDLE;
      mode_q <= MODE_512;
      last_q <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && in_valid) begin
        mode_q <= mode;
        last_q <= last_block;
      end
    end
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = in_valid ? INIT : IDLE;
      INIT:    nxt = ROUND;
      ROUND:   nxt = last_step ? FINAL : ROUND;
      FINAL:   nxt = last_q ? DONE : IDLE;
      DONE:    nxt = out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
    nxt = ab ? IDLE : nxt;
  end
  blake_step_counter #(.STEPS_PER_ROUND(STEPS_PER_ROUND), .RND_W(RND_W)) u_cnt (
    .clk       (clk),
    .rstb      (rstb),
    .clr       (state != ROUND || ab),
    .en        (state == ROUND),
    .rnd_limit (rnd_limit),
    .round_idx (round_idx),
    .step_idx  (step_idx),
    .last_step (last_step)
  );
  assign in_ready   = state == IDLE;
  assign init_round = state == INIT;
  assign round_ing  = state == ROUND;
  assign final_en   = state == FINAL;
  assign out_valid  = state == DONE;
  assign busy       = state != IDLE;
endmodule

// File: doc/blake_round_seq.md
# blake_round_seq

Parametrised round sequencer for the BLAKE compression core, the next-generation control FSM for both BLAKE-512 and BLAKE-256. It accepts one message block per valid/ready handshake and sequences the phases of one compression:

- initialisation pulse;
- `ROUNDS × STEPS_PER_ROUND` round-step cycles;
- finalisation pulse;
- digest-valid handshake on the last block.

It sits between the message-block front end and the G-function datapath. It supplies the datapath's round index (sigma selection) and step index (G-unit column/diagonal selection).

## Interface

Reset `rstb` is asynchronous and active-low. Clock is `clk`.

Parameters:
- `STEPS_PER_ROUND`, default 4: cycles per round (8 G evaluations / 2 G units). Legal values are 1, 2, 4, 8.
- `RND_W`, default 4: round index width. Must satisfy 2^`RND_W` ≥ 16.

Ports:
- `clk` — input, 1 — clock.
- `rstb` — input, 1 — asynchronous active-low reset.
- `in_valid` — input, 1 — message block, salt and counter present.
- `in_ready` — output, 1 — sequencer can accept a block.
- `mode` — input, 1 — 0 = BLAKE-512 (16 rounds), 1 = BLAKE-256 (14 rounds). Sampled on accept.
- `last_block` — input, 1 — the accepted block is the final block of the message. Sampled on accept.
- `init_round` — output, 1 — one-cycle pulse: datapath loads v from h, salt and counter.
- `round_ing` — output, 1 — high during every round-step cycle.
- `round_idx` — output, `RND_W` — current round, counting 0..R-1.
- `step_idx` — output, log2(`STEPS_PER_ROUND`), minimum 1 bit — current step within the round.
- `final_en` — output, 1 — one-cycle pulse: datapath computes h' = h ^ s ^ v_lo ^ v_hi.
- `out_valid` — output, 1 — digest valid. Held until `out_ready`.
- `out_ready` — input, 1 — consumer accepts the digest.
- `busy` — output, 1 — state ≠ IDLE.
- `abort` — input, 1 — present only with `BLAKE_ABORT_EN`.

## Operation

States: IDLE, INIT, ROUND, FINAL, DONE.

- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch `mode` and `last_block` → INIT.
- **INIT**
  - `init_round`=1. `round_idx` and `step_idx` are cleared.
  - Unconditionally → ROUND.
- **ROUND**
  - `round_ing`=1.
  - `step_idx` increments each cycle and wraps at `STEPS_PER_ROUND`-1 → 0. `round_idx` increments on that wrap.
  - When `round_idx`=R-1 and `step_idx`=`STEPS_PER_ROUND`-1 → FINAL. R=16 in BLAKE-512 mode; R=14 in BLAKE-256 mode.
- **FINAL**
  - `final_en`=1.
  - If the latched `last_block`=1 → DONE; otherwise → IDLE, ready for the next chained block.
- **DONE**
  - `out_valid`=1.
  - On `out_ready` → IDLE.
  - `in_valid` is ignored here, since `in_ready`=0.

Counter rules:
- Counters are modulo-free. They never exceed R-1 or `STEPS_PER_ROUND`-1.
- `round_idx` and `step_idx` hold 0 outside ROUND.

Input rules:
- `mode` and `last_block` changes after accept have no effect.

Reset behaviour:
- Reset mid-operation returns to IDLE immediately (asynchronous).
- No `final_en` or `out_valid` is produced for the interrupted block.

## Timing

- Reset values:
  - state = IDLE, `in_ready`=1.
  - `init_round`, `round_ing`, `final_en`, `out_valid` and `busy` = 0.
  - `round_idx` and `step_idx` = 0.
- All outputs are decoded from registered state and counters; none are combinational from inputs.
- Latency, counting the accept edge as cycle 0:
  - INIT occupies cycle 1.
  - ROUND occupies cycles 2..1+R·S.
  - FINAL occupies cycle 2+R·S.
  - DONE, with `out_valid`, starts at cycle 3+R·S.
  - BLAKE-512 with S=4: `final_en` at cycle 66, `out_valid` at cycle 67.
  - BLAKE-256 with S=4: `final_en` at cycle 58, `out_valid` at cycle 59.
- Chained block: after FINAL with `last_block`=0, `in_ready`=1 on the next cycle. Minimum block-to-block interval is R·S+3 cycles.
- DONE with `out_ready` already high: exactly one cycle of `out_valid`, then IDLE.

## Configuration

- Macro `BLAKE_ABORT_EN`.
- Defined:
  - Port `abort` exists.
  - `abort`=1 in INIT, ROUND, FINAL or DONE → IDLE on the next edge, with counters cleared.
  - `final_en` and `out_valid` are suppressed from that edge onward.
  - `abort` in IDLE is ignored.
  - If `abort` and `out_ready` are asserted together in DONE, the result is IDLE (same as either alone).
- Undefined: no `abort` port. Behaviour is otherwise identical.

## Structure

- Package `blake_seq_pkg` holds:
  - state enum (IDLE, INIT, ROUND, FINAL, DONE);
  - `ROUNDS_512`=16 and `ROUNDS_256`=14;
  - mode encoding constants.
- Sub-module `blake_step_counter` provides the round/step counter pair. Inputs: clear, enable, round limit. Outputs: `round_idx`, `step_idx`, `last_step` flag.
- The top level holds the FSM, the input latches and the output decode.

## Test plan

- **BLAKE-512 single block.** `mode`=0, `last_block`=1, S=4 → `init_round` at cycle 1; `round_idx` reaches 15/`step_idx`=3 at cycle 65; `final_en` at 66; `out_valid` at 67.
- **BLAKE-256 single block.** `mode`=1, `last_block`=1 → `final_en` at cycle 58; `round_idx` never exceeds 13.
- **Chained message.** Three back-to-back blocks, `last_block`=0,0,1 → no `out_valid` after blocks 1–2; `in_ready` returns the cycle after each `final_en`; exactly one `out_valid` at the end.
- **Output backpressure.** `out_ready` held low for 10 cycles in DONE → `out_valid` stays high; `in_valid` pulses are not accepted; `out_ready`=1 → IDLE on the next cycle.
- **Mid-run reset.** `rstb` driven low at `round_idx`=7 → all outputs return to their reset values immediately; no `final_en` afterwards.
- **Abort (`BLAKE_ABORT_EN`).** `abort` at `round_idx`=5 → IDLE next cycle; `busy`=0; `in_ready`=1; no `final_en` or `out_valid`.
